// File: rtl/mem_stage.sv
// MEM stage: holds the EX result bundle, waits for the data-SRAM response,
// aligns/extends load data and hands {reg_we, dest, result, pc} to WB.
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 75,
    parameter int MS_TO_WS_BUS_WD = 70,
    parameter int MS_TO_ES_BUS_WD = 39
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_TO_ES_BUS_WD-1:0] ms_to_es_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata
);

    logic                       ms_valid_r;
    logic [ES_TO_MS_BUS_WD-1:0] ms_bus_r;
    logic                       rdata_buf_valid_r;
    logic [31:0]                rdata_buf_r;

    logic        mem_req_s;
    logic        res_from_mem_s;
    logic [2:0]  load_op_s;
    logic        gr_we_s;
    logic [4:0]  dest_s;
    logic [31:0] alu_result_s;
    logic [31:0] pc_s;
    logic        ms_ready_go_s;
    logic        ms_leave_s;
    logic        buf_capture_s;
    logic [31:0] rdata_eff_s;
    logic [31:0] final_result_s;

    // Byte/half select and extension for the load encodings; unknown ops act as LD.W.
    function automatic logic [31:0] align_load(input logic [2:0]  op,
                                               input logic [1:0]  off,
                                               input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'b00:   b = d[7:0];
            2'b01:   b = d[15:8];
            2'b10:   b = d[23:16];
            2'b11:   b = d[31:24];
            default: b = d[7:0];
        endcase
        h = off[1] ? d[31:16] : d[15:0];
        case (op)
            3'b001:  r = {{24{b[7]}}, b};
            3'b101:  r = {24'h000000, b};
            3'b010:  r = {{16{h[15]}}, h};
            3'b110:  r = {16'h0000, h};
            default: r = d;
        endcase
        return r;
    endfunction

    assign {mem_req_s, res_from_mem_s, load_op_s, gr_we_s, dest_s, alu_result_s, pc_s} = ms_bus_r;

    assign ms_ready_go_s  = !mem_req_s | data_sram_data_ok | rdata_buf_valid_r;
    assign ms_allowin     = !ms_valid_r | (ms_ready_go_s & ws_allowin);
    assign ms_to_ws_valid = ms_valid_r & ms_ready_go_s;
    assign ms_leave_s     = ms_valid_r & ms_ready_go_s & ws_allowin;
    assign buf_capture_s  = ms_valid_r & mem_req_s & !rdata_buf_valid_r
                          & data_sram_data_ok & !ws_allowin;
    assign rdata_eff_s    = rdata_buf_valid_r ? rdata_buf_r : data_sram_rdata;

    // Result selection: aligned memory data for loads, ALU result otherwise.
    always_comb begin
        final_result_s = alu_result_s;
        if (res_from_mem_s) begin
            final_result_s = align_load(load_op_s, alu_result_s[1:0], rdata_eff_s);
        end else begin
            final_result_s = alu_result_s;
        end
    end

    assign ms_to_ws_bus = {gr_we_s, dest_s, final_result_s, pc_s};
    assign ms_to_es_bus = {ms_valid_r & gr_we_s,
                           ms_valid_r & res_from_mem_s & !ms_ready_go_s,
                           dest_s, final_result_s};

    // Stage valid bit: refilled from EX whenever the stage can accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_r <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid_r <= es_to_ms_valid;
        end
    end

    // Latched EX bundle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_bus_r <= '0;
        end else if (es_to_ms_valid && ms_allowin) begin
            ms_bus_r <= es_to_ms_bus;
        end
    end

    // Response buffer keeps data_ok/rdata alive while WB is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_buf_valid_r <= 1'b0;
            rdata_buf_r       <= 32'h00000000;
        end else if (ms_leave_s) begin
            rdata_buf_valid_r <= 1'b0;
        end else if (buf_capture_s) begin
            rdata_buf_valid_r <= 1'b1;
            rdata_buf_r       <= data_sram_rdata;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a queue scoreboard of expected WB bundles.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [74:0] es_to_ms_bus;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [38:0] ms_to_es_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    int checks = 0;
    int errors = 0;
    logic [69:0] sb_q[$];

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_to_es_bus      (ms_to_es_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [74:0] mk_es(input logic mreq, input logic rfm, input logic [2:0] lop,
                                          input logic we, input logic [4:0] dst,
                                          input logic [31:0] alu, input logic [31:0] pc);
        return {mreq, rfm, lop, we, dst, alu, pc};
    endfunction

    function automatic logic [69:0] mk_ws(input logic we, input logic [4:0] dst,
                                          input logic [31:0] res, input logic [31:0] pc);
        return {we, dst, res, pc};
    endfunction

    task automatic check(input string tag, input logic [74:0] obs, input logic [74:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ev, input logic [74:0] eb, input logic wa,
                         input logic dok, input logic [31:0] rd);
        es_to_ms_valid    = ev;
        es_to_ms_bus      = eb;
        ws_allowin        = wa;
        data_sram_data_ok = dok;
        data_sram_rdata   = rd;
    endtask

    // Settle, retire any WB handshake against the scoreboard, then advance one cycle.
    task automatic tick();
        logic [69:0] exp;
        #1;
        if (ms_to_ws_valid === 1'b1 && ws_allowin === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_retire", {5'd0, ms_to_ws_bus}, 75'd0);
            end else begin
                exp = sb_q.pop_front();
                check("wb_bundle", {5'd0, ms_to_ws_bus}, {5'd0, exp});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        drive(1'b0, 75'd0, 1'b1, 1'b0, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_valid",   {74'd0, ms_to_ws_valid}, 75'd0);
        check("rst_allowin", {74'd0, ms_allowin},     75'd1);
        check("rst_fwd_we",  {74'd0, ms_to_es_bus[38]}, 75'd0);

        // ALU op
        drive(1'b1, mk_es(1'b0, 1'b0, 3'b000, 1'b1, 5'd5, 32'h00001234, 32'h1c000000), 1'b1, 1'b0, 32'h0);
        sb_q.push_back(mk_ws(1'b1, 5'd5, 32'h00001234, 32'h1c000000));
        tick();
        drive(1'b0, 75'd0, 1'b1, 1'b0, 32'h0);
        #1;
        check("alu_valid",  {74'd0, ms_to_ws_valid},   75'd1);
        check("alu_fwd_we", {74'd0, ms_to_es_bus[38]}, 75'd1);
        tick();

        // LD.B off=3, data_ok two cycles late
        drive(1'b1, mk_es(1'b1, 1'b1, 3'b001, 1'b1, 5'd6, 32'h1c000103, 32'h1c000004), 1'b1, 1'b0, 32'h0);
        sb_q.push_back(mk_ws(1'b1, 5'd6, 32'hFFFFFF80, 32'h1c000004));
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 75'd0, 1'b1, 1'b0, 32'h0);
            #1;
            check("ldb_wait_valid",   {74'd0, ms_to_ws_valid},   75'd0);
            check("ldb_wait_pending", {74'd0, ms_to_es_bus[37]}, 75'd1);
            check("ldb_wait_allowin", {74'd0, ms_allowin},       75'd0);
            tick();
        end
        drive(1'b0, 75'd0, 1'b1, 1'b1, 32'h80FF0000);
        #1;
        check("ldb_ok_valid",   {74'd0, ms_to_ws_valid},   75'd1);
        check("ldb_ok_allowin", {74'd0, ms_allowin},       75'd1);
        check("ldb_ok_pending", {74'd0, ms_to_es_bus[37]}, 75'd0);
        check("ldb_fwd_result", {43'd0, ms_to_es_bus[31:0]}, {43'd0, 32'hFFFFFF80});
        tick();

        // LD.HU off=2 followed back-to-back by LD.H off=0
        drive(1'b1, mk_es(1'b1, 1'b1, 3'b110, 1'b1, 5'd7, 32'h1c000202, 32'h1c000008), 1'b1, 1'b0, 32'h0);
        sb_q.push_back(mk_ws(1'b1, 5'd7, 32'h00009ABC, 32'h1c000008));
        tick();
        drive(1'b1, mk_es(1'b1, 1'b1, 3'b010, 1'b1, 5'd8, 32'h1c000300, 32'h1c00000c), 1'b1, 1'b1, 32'h9ABC1234);
        sb_q.push_back(mk_ws(1'b1, 5'd8, 32'hFFFF8001, 32'h1c00000c));
        #1;
        check("ldhu_b2b_allowin", {74'd0, ms_allowin}, 75'd1);
        tick();
        drive(1'b0, 75'd0, 1'b1, 1'b1, 32'h00008001);
        tick();

        // LD.W with WB stalled: response buffered, spurious data_ok ignored
        drive(1'b1, mk_es(1'b1, 1'b1, 3'b000, 1'b1, 5'd9, 32'h1c000400, 32'h1c000010), 1'b1, 1'b0, 32'h0);
        sb_q.push_back(mk_ws(1'b1, 5'd9, 32'hDEADBEEF, 32'h1c000010));
        tick();
        drive(1'b0, 75'd0, 1'b0, 1'b1, 32'hDEADBEEF);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 75'd0, 1'b0, (i == 1), (i == 1) ? 32'h11111111 : 32'h00000000);
            #1;
            check("buf_hold_valid",   {74'd0, ms_to_ws_valid},     75'd1);
            check("buf_hold_allowin", {74'd0, ms_allowin},         75'd0);
            check("buf_hold_result",  {43'd0, ms_to_ws_bus[63:32]}, {43'd0, 32'hDEADBEEF});
            tick();
        end
        drive(1'b0, 75'd0, 1'b1, 1'b0, 32'h0);
        #1;
        check("buf_release_allowin", {74'd0, ms_allowin}, 75'd1);
        tick();
        #1;
        check("buf_empty_valid", {74'd0, ms_to_ws_valid}, 75'd0);

        // Store waits for data_ok; ALU accepted as it leaves
        drive(1'b1, mk_es(1'b1, 1'b0, 3'b000, 1'b0, 5'd10, 32'h1c000500, 32'h1c000014), 1'b1, 1'b0, 32'h0);
        sb_q.push_back(mk_ws(1'b0, 5'd10, 32'h1c000500, 32'h1c000014));
        tick();
        drive(1'b0, 75'd0, 1'b1, 1'b0, 32'h0);
        #1;
        check("st_wait_valid",   {74'd0, ms_to_ws_valid},   75'd0);
        check("st_wait_fwd_we",  {74'd0, ms_to_es_bus[38]}, 75'd0);
        check("st_wait_pending", {74'd0, ms_to_es_bus[37]}, 75'd0);
        check("st_wait_allowin", {74'd0, ms_allowin},       75'd0);
        tick();
        drive(1'b1, mk_es(1'b0, 1'b0, 3'b000, 1'b1, 5'd11, 32'h0000ABCD, 32'h1c000018), 1'b1, 1'b1, 32'h55555555);
        sb_q.push_back(mk_ws(1'b1, 5'd11, 32'h0000ABCD, 32'h1c000018));
        #1;
        check("st_leave_allowin", {74'd0, ms_allowin}, 75'd1);
        tick();
        drive(1'b0, 75'd0, 1'b1, 1'b0, 32'h0);
        #1;
        check("alu_after_st_valid", {74'd0, ms_to_ws_valid}, 75'd1);
        tick();

        // Reset while a load is outstanding
        drive(1'b1, mk_es(1'b1, 1'b1, 3'b000, 1'b1, 5'd12, 32'h1c000600, 32'h1c00001c), 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b0, 75'd0, 1'b1, 1'b0, 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rst2_valid",   {74'd0, ms_to_ws_valid},   75'd0);
        check("rst2_allowin", {74'd0, ms_allowin},       75'd1);
        check("rst2_fwd_we",  {74'd0, ms_to_es_bus[38]}, 75'd0);
        drive(1'b0, 75'd0, 1'b1, 1'b1, 32'hCAFEF00D);
        #1;
        check("rst2_ok_valid", {74'd0, ms_to_ws_valid}, 75'd0);
        tick();
        drive(1'b0, 75'd0, 1'b1, 1'b0, 32'h0);
        #1;
        check("rst2_after_valid", {74'd0, ms_to_ws_valid}, 75'd0);
        tick();

        check("scoreboard_drained", 75'(sb_q.size()), 75'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
MEM pipeline stage between EX and WB of the 5-stage LoongArch-subset core. Latches the EX result bundle and waits for the data-SRAM response on memory operations. Aligns and sign/zero-extends load data and forwards {reg_we, dest, final_result, pc} to WB over the 70-bit MS-to-WS bus. Also exports a forwarding/load-use bus back to EX.

Parameters:
ES_TO_MS_BUS_WD, 75, width of EX-to-MEM bundle
MS_TO_WS_BUS_WD, 70, width of MEM-to-WB bundle
MS_TO_ES_BUS_WD, 39, width of forwarding bus to EX

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
ws_allowin  input  1  WB can accept this cycle
ms_allowin  output  1  MEM can accept from EX
es_to_ms_valid  input  1  EX offers a valid instruction
es_to_ms_bus  input  75  {mem_req[74], res_from_mem[73], load_op[72:70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}
ms_to_ws_valid  output  1  MEM offers a valid instruction to WB
ms_to_ws_bus  output  70  {reg_we[69], dest[68:64], final_result[63:32], pc[31:0]}
ms_to_es_bus  output  39  {fwd_we[38], res_from_mem_pending[37], dest[36:32], final_result[31:0]}
data_sram_data_ok  input  1  response for the outstanding data request (load or store)
data_sram_rdata  input  32  read data, valid with data_ok

Behaviour:
- Reset (synchronous, active-high, clk): ms_valid=0, rdata_buf_valid=0, bundle register=0. Outputs after reset: ms_to_ws_valid=0, ms_allowin=1, ms_to_es_bus fwd_we=0.
- Reset mid-operation (outstanding request) drops the instruction. Any data_ok on the next cycle is ignored because ms_valid=0.
- ms_ready_go = !mem_req | data_sram_data_ok | rdata_buf_valid. All gated by the latched bundle.
- ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
- ms_to_ws_valid = ms_valid & ms_ready_go.
- Valid register: if ms_allowin, ms_valid <= es_to_ms_valid.
- Bundle register: loads es_to_ms_bus when es_to_ms_valid & ms_allowin.
- Response buffer:
  - Captures data_sram_rdata and sets rdata_buf_valid when ms_valid & mem_req & !rdata_buf_valid & data_sram_data_ok & !ws_allowin.
  - Clears when the instruction leaves (ms_valid & ms_ready_go & ws_allowin).
  - Clears on reset.
- Effective rdata = rdata_buf_valid ? rdata_buf : data_sram_rdata.
- data_ok arriving while ms_valid=0, mem_req=0, or buffer already full: ignored, no state change.
- Load alignment uses off = alu_result[1:0].
  - load_op 000 LD.W: rdata unchanged. off is always 00 (EX guarantees alignment).
  - 001 LD.B: sign-extend byte rdata[8*off+7:8*off].
  - 101 LD.BU: zero-extend the same byte.
  - 010 LD.H: sign-extend half rdata[16*off[1]+15:16*off[1]].
  - 110 LD.HU: zero-extend the same half.
  - Other encodings: treated as LD.W.
- final_result = res_from_mem ? aligned load data : alu_result.
- Stores: mem_req=1, res_from_mem=0, gr_we=0. The stage still waits for data_ok, and final_result = alu_result.
- reg_we to WB = gr_we. WB applies its own valid gating.
- ms_to_es_bus:
  - fwd_we = ms_valid & gr_we.
  - res_from_mem_pending = ms_valid & res_from_mem & !ms_ready_go. EX stalls on a dest match.
  - dest and final_result are unqualified.
- Back-to-back: a new instruction can be accepted in the same cycle the current one leaves. Throughput is 1/cycle when no memory wait occurs.
- Combinational paths: data_ok → ms_allowin and data_ok → ms_to_ws_valid. No combinational path from es_to_ms_* to outputs.

Test Plan:
- ALU op: bus mem_req=0, gr_we=1, dest=5, alu_result=0x1234, pc=0x1c000000; ws_allowin=1 → next cycle ms_to_ws_valid=1, ms_to_ws_bus={1,5,0x00001234,0x1c000000}.
- LD.B with off=3, rdata=0x80FF_0000, data_ok 2 cycles late → ms_to_ws_valid=0 and res_from_mem_pending=1 while waiting. Then final_result=0xFFFFFF80 for one cycle; ms_allowin=1 that cycle.
- LD.HU with off=2 and rdata=0x9ABC_1234 → 0x00009ABC. LD.H with off=0 and rdata=0x0000_8001 → 0xFFFF8001.
- data_ok with ws_allowin=0, rdata=0xDEADBEEF → buffer holds the data. ws_allowin rises 3 cycles later → WB sees 0xDEADBEEF and rdata_buf_valid clears. A spurious data_ok inside that window is ignored.
- Store (mem_req=1, gr_we=0) → held until data_ok, with fwd_we=0. A following ALU instruction is accepted the same cycle the store leaves.
- Reset asserted while a load is outstanding → ms_to_ws_valid=0 and ms_allowin=1 next cycle. A data_ok arriving after reset is ignored.
